// File: rtl/oled_i2c_pkg.sv
// Shared definitions for the SSD1306-style I2C write target.
//   state_e           : protocol FSM states
//   CTRL_CO_BIT/DC_BIT: bit positions inside an SSD1306 control byte
//   OLED_ADDR_DEFAULT : usual 7-bit SSD1306 bus address
package oled_i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StCtrl,
    StCtrlAck,
    StByte,
    StByteAck,
    StIgnore
  } state_e;

  localparam int unsigned CTRL_CO_BIT = 7;
  localparam int unsigned CTRL_DC_BIT = 6;

  localparam logic [6:0] OLED_ADDR_DEFAULT = 7'h3C;

endpackage

// File: rtl/ssd1306_i2c_target_if.sv
// Two-wire bus as seen at the target's pads.
//   scl_i  : SCL level from the pad
//   sda_i  : SDA level from the pad (wired-AND of all drivers)
//   sda_oe : 1 = target pulls SDA low
// master modport: bus side (drives the lines, observes the pull-down).
// slave modport : the target.
interface ssd1306_i2c_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe
  );

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one asynchronous bus line plus edge strobes.
//   clk, rst : system clock, synchronous active-low reset
//   line     : raw pad level
//   level    : synchronized level
//   rise/fall: one-cycle strobes on synchronized edges
// Flops reset to 1 (idle bus level) so a reset never fakes an edge.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ssd1306_i2c_target.sv
// Write-only I2C target emulating the SSD1306 receive path.
//   clk, rst     : system clock (>= 8x SCL), synchronous active-low reset
//   bus          : SCL/SDA pad levels in, SDA pull-down enable out
//   byte_valid   : one-cycle strobe for each ACKed payload byte
//   byte_data    : payload byte, held until the next strobe
//   byte_is_data : 1 = display data, 0 = command
//   col, page    : write pointer of the next display data byte
//   frame_done   : strobe when the last cell of the frame is written
//   busy         : addressed, from address match until STOP/START
module ssd1306_i2c_target
  import oled_i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR  = OLED_ADDR_DEFAULT,
  parameter int unsigned COLS  = 128,
  parameter int unsigned PAGES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  ssd1306_i2c_target_if.slave        bus,
  output logic                       byte_valid,
  output logic [7:0]                 byte_data,
  output logic                       byte_is_data,
  output logic [6:0]                 col,
  output logic [2:0]                 page,
  output logic                       frame_done,
  output logic                       busy
);

  localparam logic [6:0] ColMax  = 7'(COLS - 1);
  localparam logic [2:0] PageMax = 3'(PAGES - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (bus.scl_i),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (bus.sda_i),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SCL level before this cycle; a START/STOP coinciding with an SCL
  // fall still sees SCL as high and takes priority over the edge.
  logic scl_was_high;
  logic start_det, stop_det, bus_cond;
  logic scl_rise_e, scl_fall_e;

  assign scl_was_high = (scl_lvl & ~scl_rise) | scl_fall;
  assign start_det    = sda_fall & scl_was_high;
  assign stop_det     = sda_rise & scl_was_high;
  assign bus_cond     = start_det | stop_det;
  assign scl_rise_e   = scl_rise & ~bus_cond;
  assign scl_fall_e   = scl_fall & ~bus_cond;

  state_e     state_q, state_d;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_done_q;
  logic       co_q, dc_q;
  logic       busy_q;
  logic       byte_valid_q, byte_is_data_q, frame_done_q;
  logic [7:0] byte_data_q;
  logic [6:0] col_q;
  logic [2:0] page_q;

  logic in_rx;
  logic addr_match;
  logic byte_end;

  always_comb begin
    in_rx = 1'b0;
    unique case (state_q)
      StAddr, StCtrl, StByte: in_rx = 1'b1;
      default:                in_rx = 1'b0;
    endcase
  end

  assign addr_match = (shift_q[7:1] == ADDR) && !shift_q[0];
  // SCL fall right after the 8th data bit: start of the ACK clock.
  assign byte_end   = scl_fall_e & byte_done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = StIdle;
    end else if (start_det) begin
      state_d = StAddr;
    end else if (scl_fall_e) begin
      unique case (state_q)
        StAddr:    if (byte_done_q) state_d = addr_match ? StAddrAck : StIgnore;
        StAddrAck: state_d = StCtrl;
        StCtrl:    if (byte_done_q) state_d = StCtrlAck;
        StCtrlAck: state_d = StByte;
        StByte:    if (byte_done_q) state_d = StByteAck;
        StByteAck: state_d = co_q ? StCtrl : StByte;
        default:   state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from state.
  always_comb begin
    bus.sda_oe = 1'b0;
    unique case (state_q)
      StAddrAck, StCtrlAck, StByteAck: bus.sda_oe = 1'b1;
      default:                         bus.sda_oe = 1'b0;
    endcase
  end

  // Shift register, control latches, payload strobe and write pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      byte_done_q    <= 1'b0;
      co_q           <= 1'b0;
      dc_q           <= 1'b0;
      busy_q         <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= '0;
      byte_is_data_q <= 1'b0;
      col_q          <= '0;
      page_q         <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus_cond) begin
        bit_cnt_q   <= '0;
        byte_done_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        if (scl_rise_e && in_rx && !byte_done_q) begin
          shift_q   <= {shift_q[6:0], sda_lvl};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
        end
        if (byte_end) begin
          byte_done_q <= 1'b0;
          unique case (state_q)
            StAddr: begin
              if (addr_match) busy_q <= 1'b1;
            end
            StCtrl: begin
              co_q <= shift_q[CTRL_CO_BIT];
              dc_q <= shift_q[CTRL_DC_BIT];
            end
            StByte: begin
              byte_valid_q   <= 1'b1;
              byte_data_q    <= shift_q;
              byte_is_data_q <= dc_q;
              if (dc_q) begin
                if (col_q == ColMax) begin
                  col_q <= '0;
                  if (page_q == PageMax) begin
                    page_q       <= '0;
                    frame_done_q <= 1'b1;
                  end else begin
                    page_q <= page_q + 3'd1;
                  end
                end else begin
                  col_q <= col_q + 7'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign col          = col_q;
  assign page         = page_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;

endmodule

// File: doc/ssd1306_i2c_target.md
Name: ssd1306_i2c_target

Overview:
I2C target (responder) that emulates the write side of an SSD1306-style OLED controller, fed by the same two-wire bus our OLED master drives. It oversamples SCL/SDA on the system clock and ACKs its 7-bit address. It parses SSD1306 control bytes (Co, D/C#) and emits every received payload byte tagged as command or display data, with a column/page write pointer. It is used as an on-FPGA loopback target for the OLED driver, and as a bus monitor.

Parameters:
ADDR, 7'h3C, 7-bit target address to ACK
COLS, 128, columns per page; column pointer wraps at COLS-1
PAGES, 8, pages per frame; page pointer wraps at PAGES-1

Ports:
clk  in  1  system clock; must be at least 8x SCL frequency
rst  in  1  synchronous, active-low reset
scl_i  in  1  raw SCL from pad (asynchronous)
sda_i  in  1  raw SDA from pad (asynchronous)
sda_oe  out  1  1 = pull SDA low; the top level drives SDA = sda_oe ? 0 : z
byte_valid  out  1  one-cycle strobe: byte_data is a completed, ACKed payload byte
byte_data  out  8  received payload byte (control bytes excluded)
byte_is_data  out  1  1 = display data (D/C#=1), 0 = command; qualified by byte_valid
col  out  7  column pointer of the next data byte
page  out  3  page pointer of the next data byte
frame_done  out  1  one-cycle strobe when a data byte is written at col=COLS-1, page=PAGES-1
busy  out  1  1 from an address match until STOP, repeated START or reset

Behaviour:
- Reset (rst=0 at a clk edge): every output is 0, col=0, page=0, state=IDLE. sda_oe releases on the same edge, including mid-ACK.
- Input path: 2-FF synchronizer on each line, plus a previous-value register. Edges are detected on synchronized values, so latency is 3 clk from the pad.
- START: SDA falls while SCL is high, in any state (repeated START included) -> ADDR, bit counter cleared.
- STOP: SDA rises while SCL is high, in any state -> IDLE. A partial byte is discarded and busy=0.
- Bits are sampled on the SCL rising edge, MSB first. The bit counter counts 0..7.
- ACK: on the SCL falling edge after bit 8, assert sda_oe. Release it on the next SCL falling edge, which ends the 9th clock.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: 8 bits received. If addr[7:1]==ADDR and R/W=0 -> ADDR_ACK and busy=1. Otherwise -> IGNORE with no ACK.
  - ADDR_ACK -> CTRL.
  - CTRL: receive the control byte and latch Co=bit7 and dc=bit6. Bits 5:0 are ignored. Always ACK -> CTRL_ACK.
  - CTRL_ACK -> BYTE.
  - BYTE: 8 bits received -> BYTE_ACK. byte_valid pulses on the SCL falling edge that starts the ACK. byte_is_data=dc.
  - BYTE_ACK: if Co=1 -> CTRL (one payload byte per control byte). If Co=0 -> BYTE (stream mode).
  - IGNORE: sda_oe=0. Wait for START or STOP.
- Reads (R/W=1) are NACKed; this block is write-only.
- Pointer: on each data byte_valid, col increments. col=COLS-1 wraps to 0 and page increments. page=PAGES-1 with col=COLS-1 wraps both to 0 and pulses frame_done.
- Command bytes do not move the pointer; the pointer is cleared only by rst.
- byte_data holds its value until the next byte_valid.
- When START/STOP coincides with an SCL edge on the same synchronized cycle, START/STOP wins and the SCL edge is ignored.

Decomposition:
- Package oled_i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, BYTE, BYTE_ACK, IGNORE), CTRL_CO_BIT=7, CTRL_DC_BIT=6, default OLED address 7'h3C.
- Sub-module i2c_line_sync: 2-FF sync plus rise/fall strobes, instantiated once per line.

Test Plan:
- START, 0x78, 0x00, 0xAE, 0xAF, STOP -> ACK on all 4 bytes. Two byte_valid with is_data=0, data 0xAE then 0xAF. col/page stay 0. busy returns to 0 after STOP.
- START, 0x78, 0x40, then 1024 bytes 0x55 -> 1024 data strobes. frame_done pulses once, on byte 1024. col=0, page=0 at the end.
- START, 0x7A (addr 0x3D) -> NACK and no strobes. Then START, 0x79 (read of 0x3C) -> NACK and IGNORE.
- START, 0x78, 0x80, 0xA4, 0xC0, 0x10 -> Co=1 mode: first strobe is command 0xA4, second is data 0x10. col=1 afterwards.
- Repeated START after 4 bits of a data byte, then 0x78, 0x40, 0x01 -> partial byte dropped. One data strobe, byte_data=0x01.
- rst=0 asserted while sda_oe=1 during an ACK -> sda_oe=0 on the next clk edge, outputs 0, col=0, page=0, and the block waits for a fresh START.
